booth_seq_multiplier: RTL and testbench

Parametrised sequential signed Booth multiplier: the multi-cycle successor to the combinational 4-bit Booth multiplier. It accepts two WIDTH-bit two's-complement operands on a start pulse and iterates radix-2 Booth steps, one per clock. It returns the full 2*WIDTH-bit product with a one-cycle done pulse. It sits in the datapath wherever area matters more than single-cycle latency, and is driven by a simple start/busy/done handshake.

---
 rtl/booth_seq_multiplier.sv | 119 +++++++++++
 tb/tb_booth_seq_multiplier.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier.sv
// Sequential signed Booth multiplier, one recoding step per clock, start/busy/done handshake.
// Define BOOTH_RADIX4_EN for modified-Booth radix-4 steps (WIDTH/2 cycles instead of WIDTH).
module booth_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_RADIX4_EN
    localparam int STEPS = WIDTH / 2;
`else
    localparam int STEPS = WIDTH;
`endif
    localparam int CW = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH+1:0]   acc;
    logic [WIDTH+1:0]   mreg;
    logic [WIDTH-1:0]   qreg;
    logic               qm1;
    logic [CW-1:0]      count;

    logic [WIDTH+1:0]   acc_sum;
    logic [WIDTH+1:0]   acc_next;
    logic [WIDTH-1:0]   q_next;
    logic               qm1_next;
    logic [WIDTH+1:0]   m_twice;

    assign m_twice = {mreg[WIDTH:0], 1'b0};

    // Two guard bits on the accumulator keep +/-2M and the most-negative square in range.
    always_comb begin
        acc_sum  = acc;
        acc_next = acc;
        q_next   = qreg;
        qm1_next = qm1;
`ifdef BOOTH_RADIX4_EN
        case ({qreg[1:0], qm1})
            3'b001, 3'b010: acc_sum = acc + mreg;
            3'b011:         acc_sum = acc + m_twice;
            3'b100:         acc_sum = acc - m_twice;
            3'b101, 3'b110: acc_sum = acc - mreg;
            default:        acc_sum = acc;
        endcase
        acc_next = {{2{acc_sum[WIDTH+1]}}, acc_sum[WIDTH+1:2]};
        q_next   = {acc_sum[1:0], qreg[WIDTH-1:2]};
        qm1_next = qreg[1];
`else
        case ({qreg[0], qm1})
            2'b01:   acc_sum = acc + mreg;
            2'b10:   acc_sum = acc - mreg;
            default: acc_sum = acc;
        endcase
        acc_next = {acc_sum[WIDTH+1], acc_sum[WIDTH+1:1]};
        q_next   = {acc_sum[0], qreg[WIDTH-1:1]};
        qm1_next = qreg[0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mreg    <= '0;
            qreg    <= '0;
            qm1     <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        acc   <= '0;
                        mreg  <= {{2{m[WIDTH-1]}}, m};
                        qreg  <= q;
                        qm1   <= 1'b0;
                        count <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    qreg  <= q_next;
                    qm1   <= qm1_next;
                    count <= count + 1'b1;
                    // The final step's result is loaded straight into product on the same edge.
                    if (count == CW'(STEPS - 1)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= {acc_next[WIDTH-1:0], q_next};
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed self-checking bench for booth_seq_multiplier (WIDTH=8), radix-2 or BOOTH_RADIX4_EN build.
module tb_booth_seq_multiplier;

`ifdef BOOTH_RADIX4_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 8;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  m;
    logic [7:0]  q;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks;
    int failures;

    booth_seq_multiplier #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .m(m),
        .q(q),
        .busy(busy),
        .done(done),
        .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present operands with start on a negedge and release start just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] mv, input logic [7:0] qv);
        @(negedge clk);
        start = 1'b1;
        m     = mv;
        q     = qv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int cyc, output bit busy_ok);
        cyc     = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (done !== 1'b1) checkOutput("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic countDones(input int ncyc, output int ndone);
        ndone = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
    endtask

    initial begin
        int cyc;
        int ndone;
        bit busy_ok;
        int last;
        int idx;
        bit busy_bad;
        logic [15:0] exp_b2b [3];
        logic [7:0]  nm [3];
        logic [7:0]  nq [3];

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        m        = '0;
        q        = '0;
        #12;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 7 * -3
        applyStimulus(8'd7, 8'hFD);
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        waitDone(cyc, busy_ok);
        checkOutput("latency", 32'(cyc), 32'(LAT));
        checkOutput("busy_during_run", 32'(busy_ok), 32'd1);
        checkOutput("busy_in_done", 32'(busy), 32'd0);
        checkOutput("prod_7x-3", 32'(product), 32'h0000FFEB);
        @(posedge clk); #1;
        checkOutput("done_pulse_1", 32'(done), 32'd0);
        checkOutput("prod_hold", 32'(product), 32'h0000FFEB);

        // Extreme operands
        applyStimulus(8'h80, 8'h80);
        waitDone(cyc, busy_ok);
        checkOutput("prod_-128x-128", 32'(product), 32'h00004000);
        applyStimulus(8'h80, 8'h7F);
        waitDone(cyc, busy_ok);
        checkOutput("prod_-128x127", 32'(product), 32'h0000C080);
        applyStimulus(8'h7F, 8'h7F);
        waitDone(cyc, busy_ok);
        checkOutput("prod_127x127", 32'(product), 32'h00003F01);

        // Zero and minus-one
        applyStimulus(8'h00, 8'hFF);
        waitDone(cyc, busy_ok);
        checkOutput("prod_0x-1", 32'(product), 32'h0);
        @(posedge clk); #1;
        checkOutput("done_pulse_0", 32'(done), 32'd0);
        applyStimulus(8'hFF, 8'hFF);
        waitDone(cyc, busy_ok);
        checkOutput("prod_-1x-1", 32'(product), 32'h1);
        @(posedge clk); #1;
        checkOutput("done_pulse_-1", 32'(done), 32'd0);

        // Start while busy is ignored and operand changes mid-run have no effect
        applyStimulus(8'd7, 8'd3);
        @(negedge clk);
        start = 1'b1;
        m     = 8'd5;
        q     = 8'd5;
        @(negedge clk);
        start = 1'b0;
        m     = 8'h9A;
        q     = 8'h3C;
        ndone = 0;
        cyc   = 2;
        while (cyc < LAT + 20) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) begin
                ndone++;
                checkOutput("prod_ignore", 32'(product), 32'd21);
            end
        end
        checkOutput("ignore_done_count", 32'(ndone), 32'd1);
        checkOutput("ignore_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-run
        applyStimulus(8'd6, 8'd4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        countDones(2 * LAT + 4, ndone);
        checkOutput("rst_no_done", 32'(ndone), 32'd0);
        applyStimulus(8'd2, 8'd2);
        waitDone(cyc, busy_ok);
        checkOutput("prod_2x2", 32'(product), 32'd4);
        @(posedge clk); #1;

        // Back-to-back with start held high, new operands offered in each DONE cycle
        exp_b2b[0] = 16'd9;  exp_b2b[1] = 16'd12; exp_b2b[2] = 16'd20;
        nm[0] = 8'd3; nm[1] = 8'd4; nm[2] = 8'd5;
        nq[0] = 8'd3; nq[1] = 8'd3; nq[2] = 8'd4;
        @(negedge clk);
        start = 1'b1;
        m     = nm[0];
        q     = nq[0];
        @(posedge clk); #1;
        idx      = 0;
        last     = 0;
        busy_bad = 1'b0;
        cyc      = 0;
        while (idx < 3 && cyc < 100) begin
            if (done === 1'b1) begin
                checkOutput($sformatf("b2b_prod_%0d", idx), 32'(product), 32'(exp_b2b[idx]));
                if (busy !== 1'b0) busy_bad = 1'b1;
                if (idx > 0) checkOutput($sformatf("b2b_spacing_%0d", idx), 32'(cyc - last), 32'(LAT + 1));
                last = cyc;
                idx++;
                if (idx < 3) begin
                    m = nm[idx];
                    q = nq[idx];
                end else begin
                    start = 1'b0;
                end
            end else if (busy !== 1'b1) begin
                busy_bad = 1'b1;
            end
            if (idx < 3) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checkOutput("b2b_done_count", 32'(idx), 32'd3);
        checkOutput("b2b_busy_shape", 32'(busy_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
